dma_transfer_ctrl: RTL
======================

// Module: dma_transfer_ctrl
// PURPOSE
//  Single-channel DMA sequencer on the shared CPU/DMA address/data bus.
//  CPU programs source, destination and word count, then pulses start.
//  Block requests the bus via HOLD/HLDA and moves each word read-then-write
//  using Read_DMA/Write_DMA, the same strobes the memory-mapped IO ports decode.
//  Releases the bus when finished and signals done.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  CW       16  word-count width
//  SRC_INC  1   source address step per word (0 = fixed IO port, e.g. 1001)
//  DST_INC  1   destination address step per word (0 = fixed IO port)
// PORTS
//  CLK          in     1   clock, all state changes on posedge
//  RST          in     1   synchronous reset, active-high
//  cfg_src      in     AW  source start address, sampled on accepted start
//  cfg_dst      in     AW  destination start address, sampled on accepted start
//  cfg_count    in     CW  number of words, sampled on accepted start
//  cfg_start    in     1   start request; level, honoured only in IDLE
//  HOLD         out    1   bus request to CPU
//  HLDA         in     1   bus grant from CPU
//  address_Bus  out    AW  shared address bus; 'z' unless in RD1/RD2/WR
//  Data_Bus     inout  DW  shared data bus; driven only in WR, else 'z'
//  Read_DMA     out    1   DMA read strobe
//  Write_DMA    out    1   DMA write strobe
//  busy         out    1   1 in any state other than IDLE
//  done         out    1   one-cycle pulse when the transfer completes
// BEHAVIOUR
//  Reset: state=IDLE; HOLD, Read_DMA, Write_DMA, busy, done = 0; address_Bus
//   and Data_Bus = 'z'; internal src/dst/remaining/buffer registers = 0.
//  States: IDLE, REQ, RD1, RD2, WR, REL.
//  IDLE: cfg_start=1 -> latch cfg_*; if cfg_count==0 -> REL (no HOLD), else REQ.
//  REQ : HOLD=1. HLDA=1 (sampled this cycle) -> RD1; else stay in REQ.
//  RD1 : HOLD=1, address_Bus=src, Read_DMA=1 (device loads its read data).
//  RD2 : HOLD=1, address_Bus=src, Read_DMA=1; buffer<=Data_Bus at end of cycle.
//  WR  : HOLD=1, address_Bus=dst, Data_Bus=buffer, Write_DMA=1. At end of cycle:
//        src+=SRC_INC, dst+=DST_INC (mod 2^AW), remaining-=1;
//        remaining==1 before decrement -> REL, else RD1.
//  REL : HOLD=0, strobes 0, buses 'z', done=1 for this one cycle -> IDLE.
//  Per word: 3 bus cycles. Start accepted at T0 with HLDA already high ->
//   done seen in cycle T0+2+3N.
//  Read_DMA and Write_DMA are never both 1; never asserted with HLDA=0.
//  HLDA falls in RD1/RD2/WR: strobes and buses go inactive that same cycle
//   (combinational on HLDA); next state REQ; current word retried from RD1 on
//   re-grant; src/dst/remaining are not advanced.
//  cfg_start while busy: ignored, no re-latch. cfg_* changes mid-transfer: no effect.
//  Count wrap: remaining is CW bits; cfg_count = 2^CW-1 is the maximum.
//  RST mid-transfer: immediate return to reset values, HOLD dropped next edge;
//   partial transfer abandoned, no done pulse.
// CONFIGURATION
//  DMA_IRQ_EN defined: adds ports irq (out, 1) and irq_ack (in, 1).
//   irq is set in REL and held until irq_ack=1; an irq_ack in the same cycle as
//   REL loses to the set. irq resets to 0.
//  DMA_IRQ_EN undefined: ports irq/irq_ack absent; completion is visible only
//   through done/busy.
// TESTING
//  1 Reset: RST=1 for 2 cycles, mid-transfer -> HOLD=0, strobes=0, buses 'z', busy=0.
//  2 Copy: src=100, dst=200, count=3, HLDA tied 1, memory 100..102=A,B,C ->
//    200..202=A,B,C; done pulses exactly once at T0+11; busy=0 the cycle after.
//  3 IO drain: SRC_INC=0, src=1001 (IO port reg=0xDEADBEEF), dst=300, count=2 ->
//    300 and 301 both = 0xDEADBEEF; address_Bus=1001 in every RD1/RD2.
//  4 Grant delay/loss: HLDA held 0 for 5 cycles -> stays in REQ, no strobes;
//    drop HLDA during WR of word 2 -> Write_DMA=0 that cycle, word 2 rewritten
//    after re-grant, final memory correct, no word skipped or duplicated.
//  5 Zero/ignored start: count=0 -> done 1 cycle after start, HOLD never 1;
//    cfg_start pulsed while busy -> no change to addresses or count.
//  6 DMA_IRQ_EN build: irq rises with done, stays 1 until irq_ack=1, then 0;
//    irq_ack held during REL -> irq still set.

Source files
------------

// File: rtl/dma_transfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dma_transfer_ctrl
//  Brief    : Single-channel DMA sequencer on the shared CPU/DMA bus.
//             Optional interrupt output enabled with macro DMA_IRQ_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dma_transfer_ctrl #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          CW      = 16,
    parameter int unsigned SRC_INC = 1,
    parameter int unsigned DST_INC = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] cfg_src,
    input  logic [AW-1:0] cfg_dst,
    input  logic [CW-1:0] cfg_count,
    input  logic          cfg_start,
    output logic          HOLD,
    input  logic          HLDA,
    output logic [AW-1:0] address_Bus,
    inout  wire  [DW-1:0] Data_Bus,
    output logic          Read_DMA,
    output logic          Write_DMA,
    output logic          busy,
`ifdef DMA_IRQ_EN
    output logic          irq,
    input  logic          irq_ack,
`endif
    output logic          done
);

    localparam logic [AW-1:0] c_src_step = AW'(SRC_INC);
    localparam logic [AW-1:0] c_dst_step = AW'(DST_INC);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_WR   = 3'd4,
        S_REL  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [CW-1:0] r_remaining;
    logic [DW-1:0] r_buffer;

    logic          w_latch;
    logic          w_capture;
    logic          w_advance;
    logic          w_addr_en;
    logic [AW-1:0] w_addr;
    logic          w_data_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_buffer    <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_src       <= cfg_src;
                r_dst       <= cfg_dst;
                r_remaining <= cfg_count;
            end
            if (w_capture) begin
                r_buffer <= Data_Bus;
            end
            if (w_advance) begin
                r_src       <= r_src + c_src_step;
                r_dst       <= r_dst + c_dst_step;
                r_remaining <= r_remaining - CW'(1);
            end
        end
    end

    // Bus-owning states gate every strobe/driver on HLDA so a revoked grant
    // frees the bus in the same cycle; the word is then retried from RD1.
    always_comb begin
        w_next    = r_state;
        HOLD      = 1'b0;
        Read_DMA  = 1'b0;
        Write_DMA = 1'b0;
        w_addr_en = 1'b0;
        w_addr    = r_src;
        w_data_en = 1'b0;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_latch = 1'b1;
                    w_next  = (cfg_count == '0) ? S_REL : S_REQ;
                end
            end
            S_REQ: begin
                HOLD = 1'b1;
                if (HLDA) begin
                    w_next = S_RD1;
                end
            end
            S_RD1: begin
                HOLD = 1'b1;
                if (HLDA) begin
                    w_addr_en = 1'b1;
                    Read_DMA  = 1'b1;
                    w_next    = S_RD2;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_RD2: begin
                HOLD = 1'b1;
                if (HLDA) begin
                    w_addr_en = 1'b1;
                    Read_DMA  = 1'b1;
                    w_capture = 1'b1;
                    w_next    = S_WR;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WR: begin
                HOLD   = 1'b1;
                w_addr = r_dst;
                if (HLDA) begin
                    w_addr_en = 1'b1;
                    w_data_en = 1'b1;
                    Write_DMA = 1'b1;
                    w_advance = 1'b1;
                    w_next    = (r_remaining == CW'(1)) ? S_REL : S_RD1;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_REL: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign address_Bus = w_addr_en ? w_addr : {AW{1'bz}};
    assign Data_Bus    = w_data_en ? r_buffer : {DW{1'bz}};
    assign busy        = (r_state != S_IDLE);

`ifdef DMA_IRQ_EN
    logic r_irq;

    // Completion set has priority over a coincident acknowledge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_irq <= 1'b0;
        end else if (r_state == S_REL) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire
